wb_instr_loader: RTL and testbench
==================================

WB_INSTR_LOADER -- requirements
Module: wb_instr_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 10, meaning the instruction-memory word-address width.
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning the number of input buffer entries (power of two, >=2).
REQ-003 Port wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 Port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 Port instruction_recv_msg  in  32  stream word from the Wishbone converter: header or instruction.
REQ-006 Port instruction_recv_val  in  1  stream word valid.
REQ-007 Port instruction_recv_rdy  out  1  loader can accept a stream word.
REQ-008 Port imem_wen  out  1  instruction-memory write request.
REQ-009 Port imem_waddr  out  ADDR_W  instruction-memory word address.
REQ-010 Port imem_wdata  out  32  instruction-memory write data.
REQ-011 Port imem_wrdy  in  1  memory accepts the write this cycle.
REQ-012 Port core_en  out  1  core enable; high only while a complete image is resident.
REQ-013 Port busy  out  1  high while in LOAD.
REQ-014 Port err  out  1  sticky: an oversize header was received.

Function
REQ-015 A stream word SHALL transfer only in a cycle with instruction_recv_val=1 and instruction_recv_rdy=1.
REQ-016 instruction_recv_rdy SHALL be 1 exactly when the buffer is not full, with no dependency on instruction_recv_val.
REQ-017 Accepted words SHALL enter a DEPTH-entry FIFO in order.
REQ-018 The FIFO SHALL accept a push and a pop in the same cycle when not full.
REQ-019 When full, the FIFO SHALL accept no push, even if a pop occurs that cycle.
REQ-020 An accepted word SHALL reach the FIFO head no earlier than the next cycle.
REQ-021 The FSM SHALL have states IDLE, LOAD and RUN.
REQ-022 In IDLE and RUN, a non-empty FIFO head SHALL be popped in one cycle and treated as header N, using bits [31:0].
REQ-023 For N=0, the FSM SHALL go to RUN, with no memory writes.
REQ-024 For 1 <= N <= 2^ADDR_W, the FSM SHALL load remaining=N, clear the address counter to 0, and go to LOAD.
REQ-025 For N > 2^ADDR_W, the module SHALL set err, drop the word, and go to IDLE, including when it came from RUN.
REQ-026 In LOAD, imem_wen SHALL equal FIFO not-empty, with imem_wdata = FIFO head and imem_waddr = address counter.
REQ-027 The FIFO SHALL pop only when imem_wen=1 and imem_wrdy=1.
REQ-028 While imem_wrdy=0, imem_wen, imem_waddr and imem_wdata SHALL be held stable.
REQ-029 On each write handshake, the address SHALL increment and remaining SHALL decrement.
REQ-030 A handshake with remaining=1 SHALL move the FSM to RUN.
REQ-031 The address counter SHALL NOT wrap during a load; at most 2^ADDR_W writes occur.
REQ-032 imem_wen SHALL be 0 outside LOAD.
REQ-033 core_en SHALL be 1 in RUN only, first rising the cycle after the final handshake or the N=0 header pop.
REQ-034 core_en SHALL drop in the cycle after a header pop that leaves RUN.
REQ-035 busy SHALL equal (state==LOAD).
REQ-036 err SHALL be cleared only by reset.
REQ-037 Counter widths SHALL be ADDR_W+1 for remaining and ADDR_W for the address.
REQ-038 The header compare SHALL be done at 32-bit width.

Reset
REQ-039 While wb_rst_i=1 at a clock edge, the next state SHALL be: state IDLE, FIFO empty, counters 0, and core_en, busy, err and imem_wen all 0.
REQ-040 instruction_recv_rdy SHALL be 1 in the first cycle after reset deasserts.
REQ-041 Reset during LOAD SHALL abort the load; a partial image is abandoned, core_en stays 0, and buffered words are discarded.

Structure
REQ-042 The shared package SHALL hold the state enum (IDLE/LOAD/RUN) and constant HDR_MAX_FN(ADDR_W) = 2^ADDR_W.
REQ-043 The FIFO SHALL be sub-module wb_loader_fifo, parameterised by width 32 and DEPTH, with val/rdy on both ports.
REQ-044 The FSM and counters SHALL reside in wb_instr_loader.

Verification
REQ-045 Scenario: reset, then stream 3, 0xA, 0xB, 0xC with imem_wrdy=1 -> writes (0,0xA), (1,0xB), (2,0xC) on consecutive cycles; core_en=1 the cycle after the third write; busy 1->0.
REQ-046 Scenario: header 2, imem_wrdy=0 for 10 cycles, 6 words offered -> exactly DEPTH words accepted, then rdy=0; imem_wen/waddr/wdata stable while stalled; after release, in-order writes, with extra words treated as the next header.
REQ-047 Scenario: header 0 -> core_en=1 with no imem_wen; then header 1, word 0x5 -> core_en drops, write (0,0x5), core_en returns.
REQ-048 Scenario: ADDR_W=4, header 17 -> err=1, no writes, state IDLE; then header 16 plus 16 words -> addresses 0..15 without wrap, then core_en=1, err still 1.
REQ-049 Scenario: header 4, 2 words written, then reset pulse -> all outputs 0, FIFO empty; a subsequent header 1, word 0x9 writes (0,0x9).
REQ-050 Scenario: full FIFO with simultaneous val=1 and pop -> no push that cycle; rdy=1 the next cycle.

Source files
------------

// File: rtl/wb_instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and
// the header size limit helper.
package wb_instr_loader_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Largest legal image size in words for a given word-address width.
  function automatic logic [31:0] HDR_MAX_FN(input int unsigned addr_w);
    return 32'(1) << addr_w;
  endfunction

endpackage

// File: rtl/wb_loader_fifo.sv
// Small synchronous FIFO with valid/ready on both ports. Push is refused
// whenever full, even if the head is popped in the same cycle, which keeps
// the ready path free of any dependency on the pop side.
module wb_loader_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_val_i,
  output logic             push_rdy_o,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             pop_val_o,
  input  logic             pop_rdy_i,
  output logic [WIDTH-1:0] pop_data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             do_push, do_pop;

  assign push_rdy_o = (count_q != FULL_CNT);
  assign pop_val_o  = (count_q != '0);
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_val_i && push_rdy_o;
  assign do_pop     = pop_val_o && pop_rdy_i;

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage is deliberately not reset; occupancy alone decides which entries are meaningful.
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wb_instr_loader.sv
// Instruction loader: buffers a word stream, interprets a size header,
// writes the following N words to instruction memory from address 0 and
// enables the core once a complete image is resident.
module wb_instr_loader
  import wb_instr_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [31:0]       instruction_recv_msg,
  input  logic              instruction_recv_val,
  output logic              instruction_recv_rdy,
  output logic              imem_wen,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_wrdy,
  output logic              core_en,
  output logic              busy,
  output logic              err
);

  localparam logic [31:0] HDR_MAX = HDR_MAX_FN(ADDR_W);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   rem_q,   rem_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              err_q,   err_d;

  logic              head_val;
  logic              head_rdy;
  logic [31:0]       head_data;

  wb_loader_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .push_val_i  (instruction_recv_val),
    .push_rdy_o  (instruction_recv_rdy),
    .push_data_i (instruction_recv_msg),
    .pop_val_o   (head_val),
    .pop_rdy_i   (head_rdy),
    .pop_data_o  (head_data)
  );

  // Headers are consumed immediately outside LOAD; inside LOAD the head
  // leaves only when the memory takes it, which holds the write stable.
  assign head_rdy   = (state_q == ST_LOAD) ? imem_wrdy : 1'b1;

  assign busy       = (state_q == ST_LOAD);
  assign core_en    = (state_q == ST_RUN);
  assign err        = err_q;
  assign imem_wen   = busy && head_val;
  assign imem_waddr = addr_q;
  assign imem_wdata = head_data;

  // FSM and counter next-state: header decode and write bookkeeping.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (head_val) begin
          if (head_data == 32'd0) begin
            state_d = ST_RUN;
          end else if (head_data <= HDR_MAX) begin
            rem_d   = head_data[ADDR_W:0];
            addr_d  = '0;
            state_d = ST_LOAD;
          end else begin
            // Oversize image: flag it, drop the header, wait for another.
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_LOAD: begin
        if (head_val && imem_wrdy) begin
          // The address only rolls over after the final write, once the
          // FSM has already left LOAD, so no write ever sees a wrapped value.
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - (ADDR_W + 1)'(1);
          if (rem_q == (ADDR_W + 1)'(1)) state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, counters and sticky error flag with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_instr_loader.sv
// Directed self-checking bench for wb_instr_loader (ADDR_W=4, DEPTH=4).
module tb_wb_instr_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i = 1'b1;
  logic [31:0]       instruction_recv_msg = '0;
  logic              instruction_recv_val = 1'b0;
  logic              instruction_recv_rdy;
  logic              imem_wen;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              imem_wrdy = 1'b1;
  logic              core_en;
  logic              busy;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  wb_instr_loader #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .wb_clk_i             (wb_clk_i),
    .wb_rst_i             (wb_rst_i),
    .instruction_recv_msg (instruction_recv_msg),
    .instruction_recv_val (instruction_recv_val),
    .instruction_recv_rdy (instruction_recv_rdy),
    .imem_wen             (imem_wen),
    .imem_waddr           (imem_waddr),
    .imem_wdata           (imem_wdata),
    .imem_wrdy            (imem_wrdy),
    .core_en              (core_en),
    .busy                 (busy),
    .err                  (err)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // Record write handshakes mid-cycle; inputs and outputs are stable here
  // and equal to what the next rising edge will see.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && imem_wen && imem_wrdy) begin
      wr_addr_q.push_back(32'(imem_waddr));
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    instruction_recv_val = 1'b0;
    tick();
    tick();
    wb_rst_i = 1'b0;
  endtask

  // Offer one word and return just after the edge that accepted it.
  task automatic push(input logic [31:0] d);
    int b;
    b = 0;
    instruction_recv_msg = d;
    instruction_recv_val = 1'b1;
    while (!instruction_recv_rdy && b < 100) begin
      tick();
      b++;
    end
    if (!instruction_recv_rdy) check("push_rdy_timeout", 32'(instruction_recv_rdy), 32'd1);
    tick();
    instruction_recv_val = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n);
    int b;
    b = 0;
    while (wr_data_q.size() < n && b < 200) begin
      tick();
      b++;
    end
    check({tag, "_wr_count"}, 32'(wr_data_q.size()), 32'(n));
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_n_writes"}, 32'(wr_data_q.size()), 32'(exp_data_q.size()));
    for (int i = 0; i < exp_data_q.size() && i < wr_data_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], exp_addr_q[i]);
      check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_data_q[i]);
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    logic [31:0] words [6];
    int          k;
    logic        acc;

    // Reset state.
    do_reset();
    check("rst_rdy",     32'(instruction_recv_rdy), 32'd1);
    check("rst_core_en", 32'(core_en),              32'd0);
    check("rst_busy",    32'(busy),                 32'd0);
    check("rst_err",     32'(err),                  32'd0);
    check("rst_wen",     32'(imem_wen),             32'd0);

    // Header 3 with three words, memory always ready.
    imem_wrdy = 1'b1;
    push(32'd3);
    push(32'hA);
    check("s1_busy_load", 32'(busy), 32'd1);
    push(32'hB);
    push(32'hC);
    check("s1_core_en_during_load", 32'(core_en), 32'd0);
    wait_writes("s1", 3);
    check("s1_core_en", 32'(core_en), 32'd1);
    check("s1_busy_done", 32'(busy), 32'd0);
    if (wr_cyc_q.size() == 3) check("s1_consecutive", 32'(wr_cyc_q[2] - wr_cyc_q[0]), 32'd2);
    expect_wr(0, 32'hA);
    expect_wr(1, 32'hB);
    expect_wr(2, 32'hC);
    compare_writes("s1");

    // Stalled memory: buffer fills, outputs hold, then drains in order.
    do_reset();
    imem_wrdy = 1'b0;
    words = '{32'h21, 32'h22, 32'd1, 32'h44, 32'd1, 32'h55};
    push(32'd2);
    k = 0;
    instruction_recv_msg = words[0];
    instruction_recv_val = 1'b1;
    for (int c = 0; c < 10; c++) begin
      acc = instruction_recv_rdy;
      tick();
      if (acc) begin
        k++;
        instruction_recv_msg = words[k];
      end
      check($sformatf("s2_stall_wen%0d", c),   32'(imem_wen),   32'd1);
      check($sformatf("s2_stall_waddr%0d", c), 32'(imem_waddr), 32'd0);
      check($sformatf("s2_stall_wdata%0d", c), imem_wdata,      32'h21);
    end
    check("s2_accepted", 32'(k), 32'(DEPTH));
    check("s2_rdy_full", 32'(instruction_recv_rdy), 32'd0);
    // Full buffer, word offered and head popped at the same edge.
    imem_wrdy = 1'b1;
    tick();
    check("s2_rdy_after_pop", 32'(instruction_recv_rdy), 32'd1);
    push(words[4]);
    push(words[5]);
    wait_writes("s2", 4);
    check("s2_core_en", 32'(core_en), 32'd1);
    check("s2_err", 32'(err), 32'd0);
    expect_wr(0, 32'h21);
    expect_wr(1, 32'h22);
    expect_wr(0, 32'h44);
    expect_wr(0, 32'h55);
    compare_writes("s2");

    // Empty image, then a one-word reload from RUN.
    do_reset();
    push(32'd0);
    tick();
    check("s3_core_en_n0", 32'(core_en), 32'd1);
    check("s3_no_write", 32'(wr_data_q.size()), 32'd0);
    push(32'd1);
    check("s3_core_en_before_pop", 32'(core_en), 32'd1);
    push(32'h5);
    check("s3_core_en_drop", 32'(core_en), 32'd0);
    check("s3_busy", 32'(busy), 32'd1);
    wait_writes("s3", 1);
    check("s3_core_en_back", 32'(core_en), 32'd1);
    expect_wr(0, 32'h5);
    compare_writes("s3");

    // Oversize header, then a maximum-size image.
    do_reset();
    push(32'd17);
    tick();
    check("s4_err", 32'(err), 32'd1);
    check("s4_idle_busy", 32'(busy), 32'd0);
    check("s4_idle_core_en", 32'(core_en), 32'd0);
    check("s4_no_write", 32'(wr_data_q.size()), 32'd0);
    push(32'd16);
    for (int i = 0; i < 16; i++) begin
      push(32'h100 + 32'(i));
      expect_wr(32'(i), 32'h100 + 32'(i));
    end
    wait_writes("s4", 16);
    check("s4_core_en", 32'(core_en), 32'd1);
    check("s4_err_sticky", 32'(err), 32'd1);
    compare_writes("s4");

    // Reset in the middle of a load with a word still buffered.
    push(32'd4);
    push(32'h61);
    push(32'h62);
    wait_writes("s5_partial", 2);
    imem_wrdy = 1'b0;
    push(32'h63);
    check("s5_core_en_partial", 32'(core_en), 32'd0);
    do_reset();
    check("s5_rst_wen",     32'(imem_wen),             32'd0);
    check("s5_rst_busy",    32'(busy),                 32'd0);
    check("s5_rst_core_en", 32'(core_en),              32'd0);
    check("s5_rst_err",     32'(err),                  32'd0);
    check("s5_rst_rdy",     32'(instruction_recv_rdy), 32'd1);
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    imem_wrdy = 1'b1;
    push(32'd1);
    push(32'h9);
    wait_writes("s5", 1);
    check("s5_core_en", 32'(core_en), 32'd1);
    check("s5_err", 32'(err), 32'd0);
    expect_wr(0, 32'h9);
    compare_writes("s5");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
